// File: rtl/contention_monitor.sv
// Contention monitor for LP-mode trios: per-wire blanking after LpTx changes,
// filtered mismatch detection, sticky per-trio P0/P1 flags and a one-cycle IRQ.
module contention_monitor #(
  parameter int NUM_TRIOS     = 1,
  parameter int FILTER_CYCLES = 4,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Enable,
  input  logic                   ErrClear,
  input  logic [3*NUM_TRIOS-1:0] LpTx,
  input  logic [3*NUM_TRIOS-1:0] LpRx,
  input  logic [3*NUM_TRIOS-1:0] LpCd,
  output logic [NUM_TRIOS-1:0]   ErrContentionP0,
  output logic [NUM_TRIOS-1:0]   ErrContentionP1,
  output logic                   ContentionIrq
);

  localparam int         NW         = 3 * NUM_TRIOS;
  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
  localparam logic [7:0] FILTER_MAX = 8'(FILTER_CYCLES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ARMED = 1'b1
  } wire_state_e;

  wire_state_e          state_q     [NW];
  wire_state_e          state_d     [NW];
  logic [NW-1:0][7:0]   blank_cnt_q, blank_cnt_d;
  logic [NW-1:0][7:0]   mis_cnt_q, mis_cnt_d;
  logic [NW-1:0]        lptx_prev_q, lptx_prev_d;
  logic [NW-1:0]        mismatch;
  logic [NW-1:0]        set_w;
  logic [NUM_TRIOS-1:0] set_p0, set_p1;
  logic [NUM_TRIOS-1:0] p0_q, p0_d, p1_q, p1_d;
  logic                 irq_q, irq_d;

  // Per-wire mismatch: driving high needs both receiver and detector high,
  // driving low must see neither of them high.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      mismatch[w] = LpTx[w] ? ~(LpRx[w] & LpCd[w]) : (LpRx[w] | LpCd[w]);
    end
  end

  // Per-wire BLANK/ARMED FSM with blank and mismatch counters.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path can infer a latch.
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    lptx_prev_d = LpTx;
    set_w       = '0;
    for (int w = 0; w < NW; w++) begin
      if (!Enable || (LpTx[w] != lptx_prev_q[w])) begin
        state_d[w]     = ST_BLANK;
        blank_cnt_d[w] = BLANK_LOAD;
        mis_cnt_d[w]   = '0;
      end else if (state_q[w] == ST_BLANK) begin
        mis_cnt_d[w] = '0;
        if (blank_cnt_q[w] == 8'd0) begin
          state_d[w] = ST_ARMED;
        end else begin
          blank_cnt_d[w] = blank_cnt_q[w] - 8'd1;
        end
      end else if (mismatch[w]) begin
        // Saturate at the filter length so a persisting fault sets only once.
        if (mis_cnt_q[w] != FILTER_MAX) begin
          mis_cnt_d[w] = mis_cnt_q[w] + 8'd1;
        end
        if (mis_cnt_q[w] == FILTER_MAX - 8'd1) begin
          set_w[w] = 1'b1;
        end
      end else begin
        mis_cnt_d[w] = '0;
      end
    end
  end

  // Trio flag merge, sticky flags with set-wins-over-clear, and IRQ on any new set.
  always_comb begin
    for (int t = 0; t < NUM_TRIOS; t++) begin
      set_p0[t] = |(set_w[3*t +: 3] & ~LpTx[3*t +: 3]);
      set_p1[t] = |(set_w[3*t +: 3] &  LpTx[3*t +: 3]);
    end
    p0_d  = (p0_q & ~{NUM_TRIOS{ErrClear}}) | set_p0;
    p1_d  = (p1_q & ~{NUM_TRIOS{ErrClear}}) | set_p1;
    irq_d = (|(set_p0 & (~p0_q | {NUM_TRIOS{ErrClear}}))) |
            (|(set_p1 & (~p1_q | {NUM_TRIOS{ErrClear}})));
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (Rst) begin
      for (int w = 0; w < NW; w++) begin
        state_q[w] <= ST_BLANK;
      end
      blank_cnt_q <= {NW{BLANK_LOAD}};
      mis_cnt_q   <= '0;
      lptx_prev_q <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        state_q[w] <= state_d[w];
      end
      blank_cnt_q <= blank_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      lptx_prev_q <= lptx_prev_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      irq_q       <= irq_d;
    end
  end

  assign ErrContentionP0 = p0_q;
  assign ErrContentionP1 = p1_q;
  assign ContentionIrq   = irq_q;

endmodule

// File: tb/tb_contention_monitor.sv
// Self-checking bench for contention_monitor (2 trios, default filter/blank).
// A behavioural model tracks, per wire, how many quiet enabled edges have
// passed since the last restart and how long the current mismatch run is.
module tb_contention_monitor;

  localparam int NT     = 2;
  localparam int NW     = 3 * NT;
  localparam int FILTER = 4;
  localparam int BLANK  = 2;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [NW-1:0] lp_tx, lp_rx, lp_cd;
  logic [NT-1:0] p0, p1;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int            since_m [NW];
  int            run_m   [NW];
  logic          prev_m  [NW];
  logic [NT-1:0] m_p0, m_p1;
  logic          m_irq;
  logic          irq_seen;
  int            n;

  contention_monitor #(
    .NUM_TRIOS    (NT),
    .FILTER_CYCLES(FILTER),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .Clk            (clk),
    .Rst            (rst),
    .Enable         (en),
    .ErrClear       (clr),
    .LpTx           (lp_tx),
    .LpRx           (lp_rx),
    .LpCd           (lp_cd),
    .ErrContentionP0(p0),
    .ErrContentionP1(p1),
    .ContentionIrq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    logic [NT-1:0] s0, s1;
    s0 = '0;
    s1 = '0;
    if (rst) begin
      for (int w = 0; w < NW; w++) begin
        since_m[w] = 0;
        run_m[w]   = 0;
        prev_m[w]  = 1'b0;
      end
      m_p0  = '0;
      m_p1  = '0;
      m_irq = 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        bit mis;
        mis = lp_tx[w] ? !(lp_rx[w] && lp_cd[w]) : (lp_rx[w] || lp_cd[w]);
        if (!en || (lp_tx[w] != prev_m[w])) begin
          since_m[w] = 0;
          run_m[w]   = 0;
        end else begin
          // Counting starts once BLANK quiet edges plus the arming edge have passed.
          if (since_m[w] > BLANK && mis) begin
            run_m[w]++;
            if (run_m[w] == FILTER) begin
              if (lp_tx[w]) s1[w/3] = 1'b1;
              else          s0[w/3] = 1'b1;
            end
          end else begin
            run_m[w] = 0;
          end
          if (since_m[w] < 1000) since_m[w]++;
        end
        prev_m[w] = lp_tx[w];
      end
      m_irq = (|(s0 & (~m_p0 | {NT{clr}}))) | (|(s1 & (~m_p1 | {NT{clr}})));
      m_p0  = (clr ? '0 : m_p0) | s0;
      m_p1  = (clr ? '0 : m_p1) | s1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("mdl_p0", 32'(p0), 32'(m_p0));
    check("mdl_p1", 32'(p1), 32'(m_p1));
    check("mdl_irq", 32'(irq), 32'(m_irq));
    irq_seen = irq_seen | irq;
  endtask

  // Steps until the selected flag bit is seen high; cnt = -1 if the bound expires.
  task automatic wait_flag(input bit use_p1, input int trio, input int max_steps, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max_steps; i++) begin
      step();
      if ((use_p1 ? p1[trio] : p0[trio]) === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    lp_tx = '0; lp_rx = '0; lp_cd = '0;
    irq_seen = 1'b0;
    #1;
    step(); step();
    check("rst_flags", {p1, p0}, 0);
    check("rst_irq", irq, 0);

    // Quiet bus: nothing may fire.
    rst = 1'b0; en = 1'b1; irq_seen = 1'b0;
    repeat (20) step();
    check("idle_flags", {p1, p0}, 0);
    check("idle_irq", irq_seen, 0);

    // Trio 0 wire B, low level with detector high: 3 edges is too short, 4 sets P0.
    lp_cd[1] = 1'b1;
    repeat (3) step();
    lp_cd[1] = 1'b0;
    step();
    check("p0_short", p0, 0);
    lp_cd[1] = 1'b1;
    repeat (4) step();
    check("p0_set", p0, 2'b01);
    check("p0_irq", irq, 1);
    lp_cd[1] = 1'b0;
    step();
    check("p0_irq_once", irq, 0);
    check("p0_sticky", p0, 2'b01);

    // Clear with mismatch gone.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_p0", p0, 0);

    // Wire A rises with receiver low: change edge, then blank, arm and filter.
    lp_tx[0] = 1'b1;
    wait_flag(1'b1, 0, 20, n);
    check("p1_latency", n, BLANK + 2 + FILTER);
    irq_seen = 1'b0;
    repeat (5) step();
    check("sat_no_irq", irq_seen, 0);

    // Trio 1 wire C P1 fault; ErrClear lands on the setting edge: set wins.
    lp_tx[5] = 1'b1;
    repeat (BLANK + 1 + FILTER) step();
    check("pre_setwin_p1", p1, 2'b01);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("setwin_p1", p1, 2'b10);
    check("setwin_irq", irq, 1);

    lp_tx = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    check("restore_flags", {p1, p0}, 0);

    // Reset after 3 of 4 mismatch edges discards progress.
    lp_rx[2] = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_flags", {p1, p0}, 0);
    check("midrst_irq", irq, 0);
    rst = 1'b0;
    wait_flag(1'b0, 0, 20, n);
    check("post_rst_latency", n, BLANK + 1 + FILTER);

    // Disabled with continuous mismatch: flags hold, nothing new.
    en = 1'b0;
    lp_cd[4] = 1'b1;
    irq_seen = 1'b0;
    repeat (50) step();
    check("dis_p0_hold", p0, 2'b01);
    check("dis_p1", p1, 0);
    check("dis_irq", irq_seen, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("dis_clr", p0, 0);

    // Re-enable: both trios set together, single IRQ pulse.
    en = 1'b1;
    wait_flag(1'b0, 0, 20, n);
    check("reen_latency", n, BLANK + 1 + FILTER);
    check("multi_p0", p0, 2'b11);
    check("multi_irq", irq, 1);
    step();
    check("multi_irq_once", irq, 0);

    lp_rx = '0; lp_cd = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_all", {p1, p0}, 0);

    // LpTx toggling every 2 edges never leaves BLANK.
    lp_rx[3] = 1'b1; lp_cd[3] = 1'b1;
    irq_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) lp_tx[3] = ~lp_tx[3];
      step();
    end
    check("toggle_flags", {p1, p0}, 0);
    check("toggle_irq", irq_seen, 0);
    lp_tx = '0; lp_rx = '0; lp_cd = '0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 99) != 0);
      clr = ($urandom_range(0, 19) == 0);
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 29) == 0) lp_tx[w] = ~lp_tx[w];
        if ($urandom_range(0, 14) == 0) begin
          lp_rx[w] = 1'($urandom_range(0, 1));
          lp_cd[w] = 1'($urandom_range(0, 1));
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
